// File: rtl/fll_cfg_master.sv
// fll_cfg_master: single-beat command to four-phase req/ack initiator for the FLL config port, plus lock synchronizer.
// Optional feature macro: FLL_CFG_TIMEOUT_EN (per-phase handshake timeout and rsp_err_o).
// Ports:
//   clk_i, rstn_i                 SoC clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o     command handshake; cmd_wrn_i (1 = read), cmd_add_i, cmd_wdata_i
//   rsp_valid_o                   one-cycle completion pulse with rsp_rdata_o and rsp_err_o
//   fll_req_o, fll_wrn_o, fll_add_o, fll_data_o   to the FLL config port
//   fll_ack_i (asynchronous), fll_r_data_i         from the FLL config port
//   fll_lock_i / lock_o           raw and synchronized FLL lock
module fll_cfg_master #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_wrn_i,
    input  logic [1:0]  cmd_add_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        fll_req_o,
    output logic        fll_wrn_o,
    output logic [1:0]  fll_add_o,
    output logic [31:0] fll_data_o,
    input  logic        fll_ack_i,
    input  logic [31:0] fll_r_data_i,
    input  logic        fll_lock_i,
    output logic        lock_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT_LOW = 2'd2} state_t;

    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 4) begin : g_param_check
        $error("fll_cfg_master: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 4");
    end

    state_t            r_state, w_state;
    logic [SYNC_STAGES-1:0] r_ack_sync, r_lock_sync;
    logic              r_ready;
    logic              r_req, w_req;
    logic              r_wrn, w_wrn;
    logic [1:0]        r_add, w_add;
    logic [31:0]       r_data, w_data;
    logic [31:0]       r_cap, w_cap;
    logic              r_err, w_err;
    logic              r_rsp_valid, w_rsp_valid;
    logic [31:0]       r_rsp_rdata, w_rsp_rdata;
    logic              r_rsp_err, w_rsp_err;
    logic              w_ack_s, w_accept, w_to;

    assign w_ack_s  = r_ack_sync[SYNC_STAGES-1];
    assign w_accept = cmd_valid_i & r_ready;

`ifdef FLL_CFG_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] r_cnt;
    assign w_to = (r_state != IDLE) && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    // Restarts on every state change so each phase gets its own budget.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_cnt <= '0;
        else         r_cnt <= (w_state != r_state) ? '0 : (r_state == IDLE) ? r_cnt : r_cnt + CW'(1);
    end
`else
    assign w_to = 1'b0;
`endif

    always_comb begin
        w_state     = r_state;
        w_req       = r_req;
        w_wrn       = r_wrn;
        w_add       = r_add;
        w_data      = r_data;
        w_cap       = r_cap;
        w_err       = r_err;
        w_rsp_valid = 1'b0;
        w_rsp_rdata = r_rsp_rdata;
        w_rsp_err   = r_rsp_err;
        case (r_state)
            IDLE: if (w_accept) begin
                w_wrn   = cmd_wrn_i;
                w_add   = cmd_add_i;
                w_data  = cmd_wdata_i;
                w_req   = 1'b1;
                w_err   = 1'b0;
                w_cap   = '0;
                w_state = REQ;
            end
            REQ: if (w_ack_s) begin
                // Read data is sampled only once the synchronized ack proves it stable.
                w_cap   = r_wrn ? fll_r_data_i : '0;
                w_req   = 1'b0;
                w_state = WAIT_LOW;
            end else if (w_to) begin
                w_req   = 1'b0;
                w_err   = 1'b1;
                w_state = WAIT_LOW;
            end
            WAIT_LOW: if (!w_ack_s || w_to) begin
                w_rsp_valid = 1'b1;
                w_rsp_err   = r_err | w_to;
                w_rsp_rdata = (r_err | w_to) ? '0 : r_cap;
                w_state     = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= IDLE;
            r_ack_sync  <= '0;
            r_lock_sync <= '0;
            r_ready     <= 1'b0;
            r_req       <= 1'b0;
            r_wrn       <= 1'b0;
            r_add       <= '0;
            r_data      <= '0;
            r_cap       <= '0;
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_ack_sync  <= {r_ack_sync[SYNC_STAGES-2:0], fll_ack_i};
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], fll_lock_i};
            r_ready     <= (w_state == IDLE);
            r_req       <= w_req;
            r_wrn       <= w_wrn;
            r_add       <= w_add;
            r_data      <= w_data;
            r_cap       <= w_cap;
            r_err       <= w_err;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_err   <= w_rsp_err;
        end
    end

    assign cmd_ready_o = r_ready;
    assign fll_req_o   = r_req;
    assign fll_wrn_o   = r_wrn;
    assign fll_add_o   = r_add;
    assign fll_data_o  = r_data;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;
    assign lock_o      = r_lock_sync[SYNC_STAGES-1];
endmodule

// File: tb/tb_fll_cfg_master.sv
// tb_fll_cfg_master: scoreboard bench for fll_cfg_master with loopback and stuck ack.
module tb_fll_cfg_master;
    logic        clk_i = 0, rstn_i = 1;
    logic        cmd_valid_i = 0, cmd_wrn_i = 0;
    logic [1:0]  cmd_add_i = 0;
    logic [31:0] cmd_wdata_i = 0, fll_r_data_i = 0;
    logic        fll_lock_i = 0, loop_en = 1, ack_force = 0;
    logic        cmd_ready_o, rsp_valid_o, rsp_err_o, fll_req_o, fll_wrn_o, fll_ack_i, lock_o;
    logic [31:0] rsp_rdata_o, fll_data_o;
    logic [1:0]  fll_add_o;

    typedef struct {logic [31:0] rdata; logic err; int acc; int lat;} exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    int cyc = 0, n_cmp = 0, n_err = 0, n_rsp = 0, n_push = 0;

    assign fll_ack_i = loop_en ? fll_req_o : ack_force;

    fll_cfg_master #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wrn_i(cmd_wrn_i),
        .cmd_add_i(cmd_add_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .fll_req_o(fll_req_o), .fll_wrn_o(fll_wrn_o), .fll_add_o(fll_add_o), .fll_data_o(fll_data_o),
        .fll_ack_i(fll_ack_i), .fll_r_data_i(fll_r_data_i),
        .fll_lock_i(fll_lock_i), .lock_o(lock_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk_i) begin
        if (rstn_i && rsp_valid_o) begin
            n_rsp = n_rsp + 1;
            if (exp_q.size() == 0) chk("unexpected_rsp", 32'(rsp_valid_o), 32'd0);
            else begin
                mon_e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata_o, mon_e.rdata);
                chk("rsp_err", 32'(rsp_err_o), 32'(mon_e.err));
                chk("rsp_latency", cyc - mon_e.acc, mon_e.lat);
            end
        end
    end

    task automatic send(input logic wrn, input logic [1:0] add, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int lat,
                        input bit push, output int acc);
        int t = 0;
        cmd_valid_i = 1; cmd_wrn_i = wrn; cmd_add_i = add; cmd_wdata_i = wd;
        while (!cmd_ready_o && t < 40) begin @(negedge clk_i); t++; end
        chk("cmd_accept", 32'(cmd_ready_o), 32'd1);
        acc = cyc + 1;
        if (push) begin
            exp_q.push_back('{exp_rd, exp_err, acc, lat});
            n_push++;
        end
        @(negedge clk_i);
        cmd_valid_i = 0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 60) begin @(negedge clk_i); t++; end
        chk("drain", exp_q.size(), 32'd0);
    endtask

    task automatic count_req(output int cnt);
        int t = 0;
        cnt = 0;
        while (fll_req_o && t < 40) begin cnt++; @(negedge clk_i); t++; end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, cnt;
        #1 rstn_i = 0;
        #3;
        chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
        chk("rst_fll_req", 32'(fll_req_o), 32'd0);
        chk("rst_fll_wrn", 32'(fll_wrn_o), 32'd0);
        chk("rst_fll_add", 32'(fll_add_o), 32'd0);
        chk("rst_fll_data", fll_data_o, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        chk("rst_lock", 32'(lock_o), 32'd0);
        @(negedge clk_i); @(negedge clk_i);
        rstn_i = 1;
        @(negedge clk_i);
        chk("ready_after_release", 32'(cmd_ready_o), 32'd1);

        send(0, 2'd2, 32'hDEADBEEF, 32'd0, 0, 6, 1, a0);
        chk("wr_fll_req", 32'(fll_req_o), 32'd1);
        chk("wr_fll_wrn", 32'(fll_wrn_o), 32'd0);
        chk("wr_fll_add", 32'(fll_add_o), 32'd2);
        chk("wr_fll_data", fll_data_o, 32'hDEADBEEF);
        chk("wr_ready_low", 32'(cmd_ready_o), 32'd0);
        count_req(cnt);
        chk("wr_req_cycles", cnt, 32'd3);
        drain();
        chk("fll_data_hold", fll_data_o, 32'hDEADBEEF);

        fll_r_data_i = 32'h12345678;
        send(1, 2'd1, 32'd0, 32'h12345678, 0, 6, 1, a0);
        chk("rd_fll_wrn", 32'(fll_wrn_o), 32'd1);
        chk("rd_fll_add", 32'(fll_add_o), 32'd1);
        drain();
        send(0, 2'd3, 32'h0BADF00D, 32'd0, 0, 6, 1, a0);
        drain();

        fll_r_data_i = 32'hA5A5_0F0F;
        send(1, 2'd0, 32'd0, 32'hA5A5_0F0F, 0, 6, 1, a0);
        send(1, 2'd1, 32'd0, 32'hA5A5_0F0F, 0, 6, 1, a1);
        send(1, 2'd2, 32'd0, 32'hA5A5_0F0F, 0, 6, 1, a2);
        chk("b2b_gap1", a1 - a0, 32'd7);
        chk("b2b_gap2", a2 - a1, 32'd7);
        drain();
        repeat (10) @(negedge clk_i);

`ifdef FLL_CFG_TIMEOUT_EN
        loop_en = 0; ack_force = 0;
        send(0, 2'd0, 32'hCAFEF00D, 32'd0, 1, 17, 1, a0);
        count_req(cnt);
        chk("to_req_cycles", cnt, 32'd16);
        drain();
        loop_en = 1;
        fll_r_data_i = 32'h5555_AAAA;
        send(1, 2'd3, 32'd0, 32'h5555_AAAA, 0, 6, 1, a0);
        drain();
`endif

        send(0, 2'd1, 32'h11112222, 32'd0, 0, 6, 0, a0);
        @(negedge clk_i);
        chk("pre_rst_req", 32'(fll_req_o), 32'd1);
        rstn_i = 0;
        #1;
        chk("midrst_req", 32'(fll_req_o), 32'd0);
        chk("midrst_ready", 32'(cmd_ready_o), 32'd0);
        chk("midrst_data", fll_data_o, 32'd0);
        @(negedge clk_i); @(negedge clk_i);
        rstn_i = 1;
        @(negedge clk_i);
        chk("midrst_ready_after", 32'(cmd_ready_o), 32'd1);
        repeat (10) @(negedge clk_i);

        fll_lock_i = 1;
        @(negedge clk_i);
        chk("lock_1cyc", 32'(lock_o), 32'd0);
        @(negedge clk_i);
        chk("lock_2cyc", 32'(lock_o), 32'd1);
        fll_lock_i = 0;
        repeat (3) @(negedge clk_i);
        chk("lock_fall", 32'(lock_o), 32'd0);
        fll_lock_i = 1;
        @(negedge clk_i);
        fll_lock_i = 0;
        cnt = 0;
        repeat (5) begin
            if (lock_o) cnt++;
            @(negedge clk_i);
        end
        chk("lock_glitch_width", cnt, 32'd1);

        chk("rsp_count", n_rsp, n_push);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
